// File: rtl/intl_pkg.sv
// Purpose : shared types and constants for the interlock collector slice.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package intl_pkg;

    localparam int MAX_SRC = 32;
    localparam int IDX_W   = 5;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_FAULT  = 2'd1,
        ST_CLEAR  = 2'd2,
        ST_CHECK  = 2'd3
    } intl_state_t;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_SRC-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/intl_debounce.sv
// Purpose : per-source debounce counter plus sticky fault latch.
// Latency : latch sets on the edge after the run of high samples reaches limit (limit=0 -> 1 cycle).
// Backpressure: none; level in, level out.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   src        raw fault level from the detector
//   mask       1 = source ignored; counter held at 0, existing latch kept
//   limit      number of consecutive high cycles required before latching
//   force_clr  held high while the collector runs a clear; zeroes counter and latch
//   latched    sticky fault bit
module intl_debounce (
    input  logic        clk,
    input  logic        rst,
    input  logic        src,
    input  logic        mask,
    input  logic [31:0] limit,
    input  logic        force_clr,
    output logic        latched
);

    logic [31:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || force_clr) begin
            cnt     <= '0;
            latched <= 1'b0;
        end else if (mask) begin
            cnt <= '0;
        end else if (src) begin
            // Compare the pre-increment count so limit=0 latches on the first high sample.
            if (cnt >= limit) begin
                latched <= 1'b1;
            end
            // Saturate so a long-standing fault never wraps back below the limit.
            if (cnt != 32'hFFFF_FFFF) begin
                cnt <= cnt + 32'd1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/intl_collector.sv
// Purpose : mask/debounce/latch interlock flags, record first fault, drive trip and clear sequence.
// Latency : latch -> o_intl / o_first_* / FAULT state one cycle later; clear pulse lasts CLR_HOLD cycles.
// Backpressure: none; all inputs are levels, i_clr is edge-detected internally.
//
// Ports:
//   i_clk, i_rst    clock and synchronous active-high reset
//   i_intl_src      raw per-source fault levels (1 = fault)
//   i_intl_mask     1 = source ignored
//   i_debounce      consecutive high cycles before a source latches
//   i_clr           operator clear request (rising edge acts, only in FAULT)
//   o_intl          registered OR of the latched bits
//   o_pwr_off       power-stage disable, high in FAULT/CLEAR/CHECK
//   o_intl_latched  sticky per-source fault bits
//   o_first_idx     index of the first source to latch; o_first_valid qualifies it
//   o_clr_pulse     clear fed back to the detectors, high for the whole CLEAR state
//   o_state         FSM state for debug
module intl_collector
    import intl_pkg::*;
#(
    parameter int N_SRC    = 8,
    parameter int CLR_HOLD = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_SRC-1:0]     i_intl_src,
    input  logic [N_SRC-1:0]     i_intl_mask,
    input  logic [31:0]          i_debounce,
    input  logic                 i_clr,
    output logic                 o_intl,
    output logic                 o_pwr_off,
    output logic [N_SRC-1:0]     o_intl_latched,
    output logic [IDX_W-1:0]     o_first_idx,
    output logic                 o_first_valid,
    output logic                 o_clr_pulse,
    output logic [1:0]           o_state
);

    localparam logic [31:0] HOLD_LAST = 32'(CLR_HOLD - 1);

    intl_state_t          state_q;
    intl_state_t          state_nxt;
    logic [N_SRC-1:0]     latched;
    logic [MAX_SRC-1:0]   latched_ext;
    logic                 clr_q;
    logic                 clr_rise;
    logic [31:0]          hold_cnt;
    logic                 hold_done;
    logic                 src_active;
    logic                 in_clear;
    logic                 intl_q;
    logic                 first_vld_q;
    logic [IDX_W-1:0]     first_idx_q;

    assign in_clear   = (state_q == ST_CLEAR);
    assign clr_rise   = i_clr & ~clr_q;
    assign hold_done  = (hold_cnt == HOLD_LAST);
    assign src_active = |(i_intl_src & ~i_intl_mask);

    // Per-source debounce and latch; all are wiped together while clearing.
    for (genvar k = 0; k < N_SRC; k++) begin : g_src
        intl_debounce u_deb (
            .clk       (i_clk),
            .rst       (i_rst),
            .src       (i_intl_src[k]),
            .mask      (i_intl_mask[k]),
            .limit     (i_debounce),
            .force_clr (in_clear),
            .latched   (latched[k])
        );
    end

    // Widen to the package vector size for the shared priority encoder.
    always_comb begin
        latched_ext = '0;
        for (int i = 0; i < N_SRC; i++) begin
            latched_ext[i] = latched[i];
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_NORMAL: if (|latched)  state_nxt = ST_FAULT;
            ST_FAULT:  if (clr_rise)  state_nxt = ST_CLEAR;
            ST_CLEAR:  if (hold_done) state_nxt = ST_CHECK;
            ST_CHECK:  state_nxt = src_active ? ST_FAULT : ST_NORMAL;
            default:   state_nxt = ST_NORMAL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_NORMAL;
            clr_q       <= 1'b0;
            hold_cnt    <= '0;
            intl_q      <= 1'b0;
            first_vld_q <= 1'b0;
            first_idx_q <= '0;
        end else begin
            state_q  <= state_nxt;
            clr_q    <= i_clr;
            intl_q   <= |latched;
            hold_cnt <= in_clear ? hold_cnt + 32'd1 : 32'd0;

            // The record survives a clear that finds a source still active;
            // it is only released when the check comes back clean.
            if (state_q == ST_CHECK && !src_active) begin
                first_vld_q <= 1'b0;
                first_idx_q <= '0;
            end else if (!first_vld_q && |latched) begin
                first_vld_q <= 1'b1;
                first_idx_q <= lowest_set(latched_ext);
            end
        end
    end

    assign o_intl         = intl_q;
    assign o_pwr_off      = (state_q != ST_NORMAL);
    assign o_clr_pulse    = in_clear;
    assign o_state        = state_q;
    assign o_intl_latched = latched;
    assign o_first_idx    = first_idx_q;
    assign o_first_valid  = first_vld_q;

endmodule
